// File: rtl/par2ser.sv
// Parallel-to-serial converter: valid/ready word input, one serial bit per enabled cycle.
// A one-word holding buffer lets consecutive words stream out with no idle cycle.
module par2ser #(
    parameter int unsigned LENGTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              direct,
    input  logic              ivalid,
    input  logic [LENGTH-1:0] idata,
    output logic              iready,
    output logic              ovalid,
    output logic              odata,
    output logic              olast
);

    localparam int unsigned CNT_W = $clog2(LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

    logic [LENGTH-1:0] sh_q, sh_d;
    logic [LENGTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              dir_q, dir_d;
    logic              hold_valid_q, hold_valid_d;
    logic              accept;
    logic              word_end;

    // No handshake is offered while reset is asserted, so a word is never lost at the reset edge.
    assign iready   = enable & ~hold_valid_q & ~reset;
    assign accept   = ivalid & iready;
    assign word_end = busy_q & (cnt_q == CNT_LAST);

    assign ovalid = busy_q & enable;
    assign odata  = dir_q ? sh_q[0] : sh_q[LENGTH-1];
    assign olast  = ovalid & (cnt_q == CNT_LAST);

    // Next-state: load from hold first, else straight from the input, else go idle; shift mid-word.
    always_comb begin
        sh_d         = sh_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        dir_d        = dir_q;
        hold_valid_d = hold_valid_q;

        if (enable) begin
            if (!busy_q || word_end) begin
                if (hold_valid_q) begin
                    sh_d         = hold_q;
                    dir_d        = direct;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    hold_d       = idata;
                    hold_valid_d = accept;
                end else if (accept) begin
                    sh_d   = idata;
                    dir_d  = direct;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end else begin
                sh_d  = dir_q ? {1'b0, sh_q[LENGTH-1:1]} : {sh_q[LENGTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (accept) begin
                    hold_d       = idata;
                    hold_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_q         <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            dir_q        <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            dir_q        <= dir_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule

// File: tb/tb_par2ser.sv
// Self-checking bench for par2ser: single-word vectors, multi-cycle corner sequences,
// and a randomized loopback against a deserializer reference model.
module tb_par2ser;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       direct;
    logic       ivalid;
    logic [7:0] idata;
    logic       iready;
    logic       ovalid;
    logic       odata;
    logic       olast;

    int n_cmp = 0;
    int n_err = 0;

    par2ser #(.LENGTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .direct (direct),
        .ivalid (ivalid),
        .idata  (idata),
        .iready (iready),
        .ovalid (ovalid),
        .odata  (odata),
        .olast  (olast)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       dir;
        logic [7:0] word;
        logic [7:0] serial;   // expected bit stream, first bit in bit 7
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_word(input logic dir, input logic [7:0] w);
        direct = dir;
        idata  = w;
        ivalid = 1'b1;
        #1;
        check("accept_ready", 32'(iready), 32'd1);
        tick();
        ivalid = 1'b0;
    endtask

    task automatic collect(input int n, output logic [15:0] bits, output logic [15:0] lasts,
                           output int ovc);
        bits  = '0;
        lasts = '0;
        ovc   = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (ovalid) ovc++;
            bits  = {bits[14:0], odata};
            lasts = {lasts[14:0], olast};
            tick();
        end
    endtask

    logic [15:0] bits, lasts;
    int          ovc;
    logic [7:0]  words3[3];
    logic [31:0] ov_tr, ol_tr;
    logic [23:0] stream;
    int          wi, rdy_cnt;
    logic [31:0] rdy_tr;

    // Random loopback state
    logic [7:0] q[$];
    logic [7:0] cur, sr, exp_w;
    logic       have;
    int         sent, rcv, bc, cyc;

    initial begin
        vecs[0] = '{1'b0, 8'hD5, 8'hD5};
        vecs[1] = '{1'b1, 8'hD5, 8'hAB};
        vecs[2] = '{1'b0, 8'hA5, 8'hA5};
        vecs[3] = '{1'b1, 8'hB7, 8'hED};
        vecs[4] = '{1'b1, 8'h81, 8'h81};

        reset  = 1'b1;
        enable = 1'b1;
        direct = 1'b0;
        ivalid = 1'b0;
        idata  = '0;
        @(negedge clock);
        tick();
        reset = 1'b0;
        #1;
        check("rst_ovalid", 32'(ovalid), 32'd0);
        check("rst_odata",  32'(odata),  32'd0);
        check("rst_olast",  32'(olast),  32'd0);
        check("rst_iready", 32'(iready), 32'd1);
        tick();

        // Single words in both bit orders
        for (int v = 0; v < 5; v++) begin
            send_word(vecs[v].dir, vecs[v].word);
            collect(8, bits, lasts, ovc);
            check("vec_serial", 32'(bits[7:0]), 32'(vecs[v].serial));
            check("vec_olast",  32'(lasts[7:0]), 32'h01);
            check("vec_ovalid_cnt", 32'(ovc), 32'd8);
            #1;
            check("vec_idle_after", 32'(ovalid), 32'd0);
            tick();
        end

        // Back-to-back with ivalid held: D5, B7, 3C
        words3[0] = 8'hD5; words3[1] = 8'hB7; words3[2] = 8'h3C;
        direct = 1'b0;
        wi = 0; rdy_cnt = 0; ov_tr = '0; ol_tr = '0; stream = '0; rdy_tr = '0;
        for (int c = 0; c < 30; c++) begin
            ivalid = (wi < 3);
            idata  = (wi < 3) ? words3[wi] : 8'h00;
            #1;
            ov_tr[c] = ovalid;
            ol_tr[c] = olast;
            if (c >= 1 && c <= 24) stream = {stream[22:0], odata};
            if (ivalid && iready) begin
                rdy_tr[c] = 1'b1;
                wi++;
            end
            tick();
        end
        ivalid = 1'b0;
        check("b2b_ovalid", ov_tr[29:0], 32'h01FF_FFFE);
        check("b2b_olast",  ol_tr[29:0], 32'h0101_0100);
        check("b2b_stream", 32'(stream), 32'h00D5_B73C);
        check("b2b_accepts", rdy_tr, 32'h0000_0203);

        // Enable stall after bit 3 of A5
        send_word(1'b0, 8'hA5);
        collect(3, bits, lasts, ovc);
        check("stall_pre_bits", 32'(bits[2:0]), 32'b101);
        enable = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_ovalid", 32'(ovalid), 32'd0);
            check("stall_odata",  32'(odata),  32'd0);
            check("stall_iready", 32'(iready), 32'd0);
            tick();
        end
        enable = 1'b1;
        collect(5, bits, lasts, ovc);
        check("stall_post_bits",  32'(bits[4:0]),  32'b00101);
        check("stall_post_olast", 32'(lasts[4:0]), 32'b00001);
        check("stall_post_ovc",   32'(ovc), 32'd5);

        // Reset mid-word with a second word sitting in hold
        send_word(1'b0, 8'hFF);
        ivalid = 1'b1;
        idata  = 8'h5A;
        #1;
        check("rstmid_hold_ready", 32'(iready), 32'd1);
        tick();
        ivalid = 1'b0;
        #1;
        check("rstmid_hold_full", 32'(iready), 32'd0);
        collect(3, bits, lasts, ovc);
        check("rstmid_bits", 32'(bits[2:0]), 32'b111);
        reset = 1'b1;
        #1;
        check("rstmid_iready0", 32'(iready), 32'd0);
        tick();
        #1;
        check("rstmid_iready1", 32'(iready), 32'd0);
        check("rstmid_ovalid1", 32'(ovalid), 32'd0);
        tick();
        reset = 1'b0;
        collect(12, bits, lasts, ovc);
        check("rstmid_no_resume", 32'(ovc), 32'd0);
        send_word(1'b0, 8'h81);
        collect(8, bits, lasts, ovc);
        check("rstmid_next_word",  32'(bits[7:0]),  32'h81);
        check("rstmid_next_olast", 32'(lasts[7:0]), 32'h01);

        // Randomized loopback against a deserializer model
        direct = 1'b0;
        have = 1'b0; sent = 0; rcv = 0; bc = 0; cyc = 0; sr = '0; cur = '0;
        while (rcv < 100 && cyc < 6000) begin
            enable = ($urandom_range(9) != 0);
            if (!have && sent < 100 && $urandom_range(3) != 0) begin
                have = 1'b1;
                cur  = 8'($urandom);
            end
            ivalid = have;
            idata  = cur;
            #1;
            if (ivalid && iready) begin
                q.push_back(cur);
                have = 1'b0;
                sent++;
            end
            if (ovalid) begin
                sr = {sr[6:0], odata};
                bc++;
                check("loop_olast", 32'(olast), 32'(bc == 8));
                if (bc == 8) begin
                    bc = 0;
                    rcv++;
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL loop_extra_word: got %0h expected none", sr);
                    end else begin
                        exp_w = q.pop_front();
                        check("loop_word", 32'(sr), 32'(exp_w));
                    end
                end
            end
            tick();
            cyc++;
        end
        ivalid = 1'b0;
        enable = 1'b1;
        check("loop_rcv_count", 32'(rcv), 32'd100);
        check("loop_queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
